// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small byte FIFO.
// Frames are 8N1 or 8E1/8O1, LSB first, and queued frames go out back-to-back.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx_done,
    output logic                          tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);
    localparam logic PEN  = (PARITY_EN != 0);
    localparam logic PODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    head;
    logic          push;
    logic          pop;
    logic          empty;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [2:0]    idx;
    logic [2:0]    idx_n;
    logic [7:0]    shreg;
    logic [7:0]    shreg_n;
    logic          par;
    logic          par_n;
    logic          tx_n;
    logic          bit_end;

    assign full       = (count == DEPTH);
    assign empty      = (count == '0);
    assign fifo_count = count;
    assign head       = mem[rd_ptr];
    assign push       = wr_en && !full;
    assign bit_end    = (cnt == LAST);
    assign busy       = (state != IDLE);
    assign tx_done    = (state == STOP) && bit_end;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer width equals log2(depth), so increments wrap for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            overflow <= wr_en && full;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            par   <= 1'b0;
            tx    <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            par   <= par_n;
            tx    <= tx_n;
        end
    end

    // tx is registered: each branch selects the level for the next cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        shreg_n = shreg;
        par_n   = par;
        tx_n    = tx;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                tx_n  = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = DATA;
                    tx_n    = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (idx == 3'd7) begin
                        state_n = PEN ? PARITY : STOP;
                        tx_n    = PEN ? par : 1'b1;
                    end else begin
                        idx_n   = idx + 1'b1;
                        shreg_n = shreg >> 1;
                        tx_n    = shreg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                tx_n    = 1'b1;
            end
        endcase
        // Parity comes from the byte as popped, before any shifting.
        if (pop) begin
            shreg_n = head;
            par_n   = (^head) ^ PODD;
            idx_n   = '0;
        end
    end

endmodule
